regs_access_ctrl: RTL
=====================

Name: regs_access_ctrl

Overview:
- Initiator-side sequencer that drives the CPU register file's write port and both read ports.
- Accepts operand-fetch requests (rs/rt) over a valid/ready handshake, issues the reads, and captures the registered read data one cycle later. It returns both operands over a held valid/ready response channel.
- Accepts writeback requests, stages them one cycle, and drives the register file write port. Writes to register 0 are dropped.
- Sits between the decode/execute stages and the register file.

Parameters:
- DATA_W, 32, operand and write data width
- ADDR_W, 5, register index width (32 registers)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  operand request valid
- req_ready  out  1  high in IDLE only
- req_rs  in  ADDR_W  source register A index
- req_rt  in  ADDR_W  source register B index
- req_rs_en  in  1  operand A needed
- req_rt_en  in  1  operand B needed
- rsp_valid  out  1  operands valid
- rsp_ready  in  1  consumer accepts operands
- rsp_a  out  DATA_W  operand A
- rsp_b  out  DATA_W  operand B
- wb_valid  in  1  writeback valid
- wb_ready  out  1  always 1 when out of reset
- wb_reg  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- rf_write_en  out  1  register file write enable
- rf_write_reg  out  ADDR_W  register file write index
- rf_write_data  out  DATA_W  register file write data
- rf_read_en1  out  1  register file read port 1 enable
- rf_read_reg1  out  ADDR_W  register file read port 1 index
- rf_read_en2  out  1  register file read port 2 enable
- rf_read_reg2  out  ADDR_W  register file read port 2 index
- rf_read_data1  in  DATA_W  read port 1 data, registered by the register file
- rf_read_data2  in  DATA_W  read port 2 data, registered by the register file

Behaviour:
- Register file contract: read data is captured at the posedge ending the issue cycle and is valid the following cycle. Writes land at the negedge inside the cycle rf_write_en is high, so they are visible to a read issued in that same cycle.
- Reset (rst_n=0 at posedge): FSM=IDLE.
  - rsp_valid, rsp_a, rsp_b = 0.
  - rf_write_en, rf_read_en1, rf_read_en2 = 0.
  - rf_* index/data outputs = 0.
  - Writeback stage cleared.
  - wb_ready = 0 while in reset.
- FSM states IDLE, READ, CAPT, RESP:
  - IDLE: req_ready=1. On req_valid, latch rs, rt, rs_en, rt_en and go to READ.
  - READ (1 cycle):
    - rf_read_reg1=rs_q, rf_read_reg2=rt_q.
    - rf_read_en1 = rs_en_q && rs_q!=0; rf_read_en2 likewise for rt.
    - Go to CAPT.
  - CAPT (1 cycle): rsp_a = rf_read_data1 if rf_read_en1 was high, else 0; rsp_b likewise. Set rsp_valid=1 and go to RESP.
  - RESP: hold rsp_a, rsp_b and rsp_valid stable. On rsp_ready, clear rsp_valid and go to IDLE.
- Throughput and latency:
  - Request accepted in cycle N → rsp_valid in cycle N+3.
  - Minimum 4 cycles per request.
  - rsp_ready held high on entry to RESP returns to IDLE in cycle N+4.
- Writeback path:
  - wb_valid accepted in cycle N (wb_ready=1 whenever rst_n=1).
  - Registered, then driven in cycle N+1: rf_write_en = (wb_reg_q!=0), rf_write_reg = wb_reg_q, rf_write_data = wb_data_q.
  - rf_write_en is 0 in any cycle not preceded by an accepted writeback.
  - Back-to-back writebacks are sustained at one per cycle.
- Ordering: an operand request observes every writeback accepted on or before its request-accept cycle. That write lands during the READ cycle at the latest, so no forwarding is needed. Writebacks accepted after the accept cycle are never reflected.
- Register 0 always reads 0: no rf read is issued, and writes to it are suppressed.
- Operand not enabled: its read port enable stays low and the operand returns 0.
- Simultaneous request and writeback to the same register in the same cycle: the response carries the new value.
- rsp_ready high outside RESP: ignored.
- req_valid outside IDLE: ignored (req_ready=0).
- Reset mid-operation (any state): the transaction is abandoned, no response is issued, and any staged writeback is discarded.

Decomposition:
- Shared package: ADDR_W and DATA_W constants, plus the FSM state enum (IDLE, READ, CAPT, RESP).
- One natural sub-module, regs_wb_stage: the one-entry writeback register with register-0 suppression.
- The read FSM stays in the top module.

Test Plan:
- Reset then idle → all rf enables 0, rsp_valid 0, req_ready 1, wb_ready 1.
- Writeback reg 5 = 0xDEADBEEF, then request rs=5, rt=0 with both enabled → rsp_a=0xDEADBEEF, rsp_b=0, rsp_valid 3 cycles after accept, rf_read_en2 never high.
- Writeback reg 7 = 0x12345678 in the same cycle as request rs=7 → rsp_a=0x12345678.
- Writeback reg 0 = 0xFFFFFFFF → rf_write_en stays 0; a later request with rs=0 returns 0.
- Response with rsp_ready low for 5 cycles → rsp_a and rsp_b stable, req_ready 0; the next req_valid is accepted only after the rsp_ready handshake.
- Assert rst_n=0 during CAPT → next cycle rsp_valid 0 and FSM IDLE; no response appears after release.

Source files
------------

// File: rtl/regs_access_ctrl_pkg.sv
// Shared constants and FSM encoding for the register-file access sequencer.
package regs_access_ctrl_pkg;

    // Default operand / write data width.
    localparam int unsigned DATA_W = 32;
    // Default register index width (32 architectural registers).
    localparam int unsigned ADDR_W = 5;

    // Operand-fetch sequencer states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StCapt = 2'd2,
        StResp = 2'd3
    } state_e;

endpackage

// File: rtl/regs_access_ctrl_if.sv
// Bundle of the request, response, writeback and register-file port signals.
// The slave modport is the sequencer's view; master is the surrounding
// pipeline plus register file.
interface regs_access_ctrl_if #(
    parameter int unsigned DATA_W = regs_access_ctrl_pkg::DATA_W,
    parameter int unsigned ADDR_W = regs_access_ctrl_pkg::ADDR_W
);

    // Operand request channel.
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs;
    logic [ADDR_W-1:0] req_rt;
    logic              req_rs_en;
    logic              req_rt_en;

    // Operand response channel.
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_a;
    logic [DATA_W-1:0] rsp_b;

    // Writeback channel.
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;

    // Register file ports.
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_read_en1;
    logic [ADDR_W-1:0] rf_read_reg1;
    logic              rf_read_en2;
    logic [ADDR_W-1:0] rf_read_reg2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;

    modport master (
        output req_valid, req_rs, req_rt, req_rs_en, req_rt_en,
        input  req_ready,
        input  rsp_valid, rsp_a, rsp_b,
        output rsp_ready,
        output wb_valid, wb_reg, wb_data,
        input  wb_ready,
        input  rf_write_en, rf_write_reg, rf_write_data,
        input  rf_read_en1, rf_read_reg1, rf_read_en2, rf_read_reg2,
        output rf_read_data1, rf_read_data2
    );

    modport slave (
        input  req_valid, req_rs, req_rt, req_rs_en, req_rt_en,
        output req_ready,
        output rsp_valid, rsp_a, rsp_b,
        input  rsp_ready,
        input  wb_valid, wb_reg, wb_data,
        output wb_ready,
        output rf_write_en, rf_write_reg, rf_write_data,
        output rf_read_en1, rf_read_reg1, rf_read_en2, rf_read_reg2,
        input  rf_read_data1, rf_read_data2
    );

endinterface

// File: rtl/regs_wb_stage.sv
// One-entry writeback staging register. A writeback accepted in one cycle is
// presented to the register file write port in the next; register 0 never
// raises the write enable.
module regs_wb_stage #(
    parameter int unsigned DATA_W = regs_access_ctrl_pkg::DATA_W,
    parameter int unsigned ADDR_W = regs_access_ctrl_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_reg,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_wb_ready,
    output logic              o_rf_write_en,
    output logic [ADDR_W-1:0] o_rf_write_reg,
    output logic [DATA_W-1:0] o_rf_write_data
);

    logic              w_accept;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_reg;
    logic [DATA_W-1:0] r_wr_data;

    // The stage drains every cycle, so it can always take a new writeback.
    assign o_wb_ready = i_rst_n;
    assign w_accept   = i_wb_valid && i_rst_n;

    // Stage the accepted writeback; enable only for non-zero destinations.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept && (i_wb_reg != '0);
            if (w_accept) begin
                r_wr_reg  <= i_wb_reg;
                r_wr_data <= i_wb_data;
            end
        end
    end

    assign o_rf_write_en   = r_wr_en;
    assign o_rf_write_reg  = r_wr_reg;
    assign o_rf_write_data = r_wr_data;

endmodule

// File: rtl/regs_access_ctrl.sv
// Register-file access sequencer: fetches up to two operands per request
// through the registered read ports and stages writebacks to the write port.
// A writeback accepted no later than the request lands before the read is
// sampled, so no forwarding path exists.
module regs_access_ctrl
    import regs_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = regs_access_ctrl_pkg::DATA_W,
    parameter int unsigned ADDR_W = regs_access_ctrl_pkg::ADDR_W
) (
    input logic               i_clk,
    input logic               i_rst_n,
    regs_access_ctrl_if.slave io_bus
);

    state_e            r_state;
    state_e            w_state_next;

    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic              r_rs_en;
    logic              r_rt_en;

    logic [DATA_W-1:0] r_rsp_a;
    logic [DATA_W-1:0] r_rsp_b;
    logic              r_rsp_valid;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_live1;
    logic              w_live2;
    logic              w_rd_en1;
    logic              w_rd_en2;
    logic              w_capture;
    logic              w_release;

    // Register 0 and disabled operands never touch the register file.
    assign w_live1  = r_rs_en && (r_rs != '0);
    assign w_live2  = r_rt_en && (r_rt != '0);
    assign w_accept = w_req_ready && io_bus.req_valid;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus handshake and read-port strobes.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_rd_en1     = 1'b0;
        w_rd_en2     = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            StIdle: begin
                w_req_ready = 1'b1;
                if (io_bus.req_valid) begin
                    w_state_next = StRead;
                end
            end
            StRead: begin
                w_rd_en1     = w_live1;
                w_rd_en2     = w_live2;
                w_state_next = StCapt;
            end
            StCapt: begin
                w_capture    = 1'b1;
                w_state_next = StResp;
            end
            StResp: begin
                if (io_bus.rsp_ready) begin
                    w_release    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Latch the request fields on acceptance; they stay put until the next one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rs    <= '0;
            r_rt    <= '0;
            r_rs_en <= 1'b0;
            r_rt_en <= 1'b0;
        end else if (w_accept) begin
            r_rs    <= io_bus.req_rs;
            r_rt    <= io_bus.req_rt;
            r_rs_en <= io_bus.req_rs_en;
            r_rt_en <= io_bus.req_rt_en;
        end
    end

    // Capture read data (or zero for skipped operands) and hold it through RESP.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp_a     <= '0;
            r_rsp_b     <= '0;
            r_rsp_valid <= 1'b0;
        end else if (w_capture) begin
            r_rsp_a     <= w_live1 ? io_bus.rf_read_data1 : '0;
            r_rsp_b     <= w_live2 ? io_bus.rf_read_data2 : '0;
            r_rsp_valid <= 1'b1;
        end else if (w_release) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign io_bus.req_ready    = w_req_ready;
    assign io_bus.rsp_valid    = r_rsp_valid;
    assign io_bus.rsp_a        = r_rsp_a;
    assign io_bus.rsp_b        = r_rsp_b;
    assign io_bus.rf_read_en1  = w_rd_en1;
    assign io_bus.rf_read_reg1 = r_rs;
    assign io_bus.rf_read_en2  = w_rd_en2;
    assign io_bus.rf_read_reg2 = r_rt;

    regs_wb_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_stage (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_wb_valid      (io_bus.wb_valid),
        .i_wb_reg        (io_bus.wb_reg),
        .i_wb_data       (io_bus.wb_data),
        .o_wb_ready      (io_bus.wb_ready),
        .o_rf_write_en   (io_bus.rf_write_en),
        .o_rf_write_reg  (io_bus.rf_write_reg),
        .o_rf_write_data (io_bus.rf_write_data)
    );

endmodule
